// File: rtl/div_share_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : div_share_pkg
//  Description : Shared definitions for the shared-divider sequencer: FSM
//                state encoding, requester-index width helper and the value
//                returned for a divide-by-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_share_pkg;

  // Sequencer states; kept as plain constants so older flows read them too.
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_ZERO = 2'd2;
  localparam state_t ST_GAP  = 2'd3;

  // Widest operand the sequencer supports; the divide-by-zero value is
  // sliced down to DATA_W by the user.
  localparam int MAX_DATA_W = 64;

  // Quotient reported when the divisor is zero (all ones).
  localparam logic [MAX_DATA_W-1:0] DBZ_RESULT = '1;

  // Width of a requester index; at least one bit even for two requesters.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage : div_share_pkg
`default_nettype wire

// File: rtl/div_share_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin pick. Returns the first asserted
//                request found searching upward from (ptr+1) mod N_REQ,
//                wrapping around, together with a valid flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import div_share_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [ID_W-1:0]  o_grant,
  output logic             o_valid
);

  // Walk the ring from farthest to nearest so the nearest hit after the
  // pointer is the one left standing; no early exit needed.
  always_comb begin
    o_valid = 1'b0;
    o_grant = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (i_req[(int'(i_ptr) + k) % N_REQ]) begin
        o_valid = 1'b1;
        o_grant = ID_W'((int'(i_ptr) + k) % N_REQ);
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/div_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : div_share_ctrl
//  Description : Round-robin sequencer sharing one sequential divider among
//                N_REQ requesters. Latches the granted operands, holds the
//                divider start high for a fixed latency (the divider gives no
//                completion flag), captures the quotient and returns it with
//                a one-cycle done pulse. Zero divisors bypass the divider.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int N_REQ       = 3,
  parameter int DATA_W      = 32,
  parameter int DIV_LATENCY = 36
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_W-1:0]     dividend_in,
  input  logic [N_REQ*DATA_W-1:0]     divisor_in,
  output logic [N_REQ-1:0]            done,
  output logic [DATA_W-1:0]           result,
  output logic [id_width(N_REQ)-1:0]  result_id,
  output logic                        dbz,
  output logic                        busy,
  output logic                        div_start,
  output logic [DATA_W-1:0]           div_dividend,
  output logic [DATA_W-1:0]           div_divisor,
  input  logic [DATA_W-1:0]           div_quotient
);

  localparam int ID_W  = id_width(N_REQ);
  localparam int CNT_W = $clog2(DIV_LATENCY + 1);

  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DIV_LATENCY);
  // Pointer starts on the last requester so requester 0 wins first.
  localparam logic [ID_W-1:0]  c_ptr_init = ID_W'(N_REQ - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  // Last granted requester; doubles as the round-robin pointer and as the
  // id of the operation in flight.
  logic [ID_W-1:0]       r_ptr;
  logic [N_REQ-1:0]      r_done;
  logic [DATA_W-1:0]     r_result;
  logic [ID_W-1:0]       r_result_id;
  logic                  r_dbz;
  logic                  r_busy;
  logic                  r_div_start;
  logic [DATA_W-1:0]     r_div_dividend;
  logic [DATA_W-1:0]     r_div_divisor;

  logic [ID_W-1:0]       w_pick;
  logic                  w_pick_vld;
  logic [DATA_W-1:0]     w_sel_dividend;
  logic [DATA_W-1:0]     w_sel_divisor;

  // --------------------------------------------------------------------------
  // Arbitration and operand selection
  // --------------------------------------------------------------------------
  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick),
    .o_valid (w_pick_vld)
  );

  assign w_sel_dividend = dividend_in[int'(w_pick)*DATA_W +: DATA_W];
  assign w_sel_divisor  = divisor_in [int'(w_pick)*DATA_W +: DATA_W];

  // --------------------------------------------------------------------------
  // Sequencer: grant, run the divider for a fixed latency, return the result.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_ptr          <= c_ptr_init;
      r_done         <= '0;
      r_result       <= '0;
      r_result_id    <= '0;
      r_dbz          <= 1'b0;
      r_busy         <= 1'b0;
      r_div_start    <= 1'b0;
      r_div_dividend <= '0;
      r_div_divisor  <= '0;
    end else begin
      // done is a single-cycle pulse unless a completion re-arms it below.
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            // Operands are frozen here; later input changes are ignored.
            r_div_dividend <= w_sel_dividend;
            r_div_divisor  <= w_sel_divisor;
            r_ptr          <= w_pick;
            r_busy         <= 1'b1;
            if (w_sel_divisor == '0) begin
              r_state <= ST_ZERO;
            end else begin
              r_state     <= ST_RUN;
              r_div_start <= 1'b1;
              r_cnt       <= c_cnt_load;
            end
          end
        end

        ST_RUN: begin
          if (r_cnt == '0) begin
            r_result    <= div_quotient;
            r_result_id <= r_ptr;
            r_dbz       <= 1'b0;
            r_done      <= N_REQ'(1) << r_ptr;
            r_div_start <= 1'b0;
            r_state     <= ST_GAP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end

        ST_ZERO: begin
          r_result    <= DBZ_RESULT[DATA_W-1:0];
          r_result_id <= r_ptr;
          r_dbz       <= 1'b1;
          r_done      <= N_REQ'(1) << r_ptr;
          r_state     <= ST_GAP;
        end

        ST_GAP: begin
          // One idle cycle with start low so the divider sees a clean
          // rising edge on the next operation.
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state     <= ST_IDLE;
          r_busy      <= 1'b0;
          r_div_start <= 1'b0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign done         = r_done;
  assign result       = r_result;
  assign result_id    = r_result_id;
  assign dbz          = r_dbz;
  assign busy         = r_busy;
  assign div_start    = r_div_start;
  assign div_dividend = r_div_dividend;
  assign div_divisor  = r_div_divisor;

endmodule : div_share_ctrl
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_div_share_ctrl
//  Description : Self-checking bench for div_share_ctrl with a behavioural
//                latency-34 divider and a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_div_share_ctrl;
  import div_share_pkg::*;

  localparam int N        = 3;
  localparam int W        = 32;
  localparam int LAT      = 36;
  localparam int DIV_MODEL_LAT = 34;
  localparam int IDW      = id_width(N);
  // Negedges from a request set in IDLE to done being visible: the grant
  // edge plus LAT+1 further edges (divider path) or one (divide-by-zero).
  localparam int CYC_DIV  = LAT + 2;
  localparam int CYC_DBZ  = 2;
  localparam logic [W-1:0] POISON = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   dividend_in = '0;
  logic [N*W-1:0]   divisor_in = '0;
  logic [N-1:0]     done;
  logic [W-1:0]     result;
  logic [IDW-1:0]   result_id;
  logic             dbz, busy, div_start;
  logic [W-1:0]     div_dividend, div_divisor;
  logic [W-1:0]     div_quotient = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int m_ptr    = N - 1;
  logic [W-1:0] op_a [N];
  logic [W-1:0] op_b [N];

  always #5 clk = ~clk;

  div_share_ctrl #(.N_REQ(N), .DATA_W(W), .DIV_LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .dividend_in(dividend_in), .divisor_in(divisor_in),
    .done(done), .result(result), .result_id(result_id), .dbz(dbz),
    .busy(busy), .div_start(div_start),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient)
  );

  // Behavioural divider: acts on the rising edge of start, shows a poison
  // value while working and the true quotient DIV_MODEL_LAT edges later.
  logic m_start_d = 1'b0;
  int   m_cnt = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  always @(posedge clk) begin
    m_start_d <= div_start;
    if (div_start && !m_start_d) begin
      m_a <= div_dividend; m_b <= div_divisor; m_cnt <= 1; div_quotient <= POISON;
    end else if (m_cnt != 0) begin
      if (m_cnt == DIV_MODEL_LAT - 1) begin
        div_quotient <= (m_b == '0) ? '1 : m_a / m_b;
        m_cnt <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  // Reference: first requester at or after ptr+1, wrapping.
  function automatic int exp_pick(input logic [N-1:0] r, input int ptr);
    for (int k = 1; k <= N; k++) if (r[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [W-1:0] exp_q(input logic [W-1:0] a, input logic [W-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i] = a; op_b[i] = b;
    dividend_in[i*W +: W] = a;
    divisor_in[i*W +: W]  = b;
  endtask

  task automatic wait_done(input int limit, output int cyc, output bit tmo, output bit saw_start);
    cyc = 0; tmo = 1'b1; saw_start = 1'b0;
    while (cyc < limit) begin
      @(negedge clk); cyc++;
      if (div_start) saw_start = 1'b1;
      if (done != '0) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0; req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_ptr = N - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0;
    repeat (3) @(negedge clk);
    n_checks++; if ({done, busy, div_start, dbz} !== '0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {done, busy, div_start, dbz}); end
    n_checks++; if ({result, result_id} !== '0) begin n_fail++; $display("FAIL reset_result: got %0h/%0d expected 0/0", result, result_id); end
    n_checks++; if ({div_dividend, div_divisor} !== '0) begin n_fail++; $display("FAIL reset_operands: got %0h/%0h expected 0/0", div_dividend, div_divisor); end
    rst_n = 1'b1; m_ptr = N - 1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int cyc; bit tmo, ss; int g;
    set_op(0, 1000, 7); req = 3'b001;
    g = exp_pick(req, m_ptr);
    wait_done(CYC_DIV + 5, cyc, tmo, ss);
    n_checks++; if (tmo || cyc != CYC_DIV) begin n_fail++; $display("FAIL single_latency: got %0d (timeout=%0b) expected %0d", cyc, tmo, CYC_DIV); end
    n_checks++; if (done !== N'(1) << g) begin n_fail++; $display("FAIL single_done: got %b expected %b", done, N'(1) << g); end
    n_checks++; if (result !== exp_q(1000, 7) || result_id !== IDW'(g) || dbz !== 1'b0) begin n_fail++; $display("FAIL single_result: got %0d id %0d dbz %b expected %0d id %0d dbz 0", result, result_id, dbz, exp_q(1000, 7), g); end
    n_checks++; if (busy !== 1'b1 || div_start !== 1'b0) begin n_fail++; $display("FAIL single_gap: got busy %b start %b expected 1 0", busy, div_start); end
    m_ptr = g; req = '0;
    @(negedge clk);
    n_checks++; if (done !== '0 || busy !== 1'b0 || result !== 32'd142) begin n_fail++; $display("FAIL single_after: got done %b busy %b result %0d expected 0 0 142", done, busy, result); end
  endtask

  task automatic test_dbz();
    int cyc; bit tmo, ss; int g;
    set_op(1, 5, 0); req = 3'b010;
    g = exp_pick(req, m_ptr);
    wait_done(CYC_DBZ + 5, cyc, tmo, ss);
    n_checks++; if (tmo || cyc != CYC_DBZ) begin n_fail++; $display("FAIL dbz_latency: got %0d (timeout=%0b) expected %0d", cyc, tmo, CYC_DBZ); end
    n_checks++; if (ss !== 1'b0) begin n_fail++; $display("FAIL dbz_no_start: got start seen %b expected 0", ss); end
    n_checks++; if (done !== N'(1) << g || result !== '1 || dbz !== 1'b1 || result_id !== IDW'(g)) begin n_fail++; $display("FAIL dbz_result: got done %b %0h dbz %b id %0d expected %b ffffffff 1 %0d", done, result, dbz, result_id, N'(1) << g, g); end
    m_ptr = g; req = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || dbz !== 1'b1 || div_start !== 1'b0) begin n_fail++; $display("FAIL dbz_hold: got busy %b dbz %b start %b expected 0 1 0", busy, dbz, div_start); end
  endtask

  task automatic test_round_robin();
    int cyc; bit tmo, ss; int g; int exp_cyc;
    do_reset();
    for (int i = 0; i < N; i++) set_op(i, W'(i * 100), W'(i + 1));
    req = '1;
    for (int op = 0; op < 4; op++) begin
      g = exp_pick(req, m_ptr);
      exp_cyc = (op == 0) ? CYC_DIV : LAT + 3;
      wait_done(exp_cyc + 5, cyc, tmo, ss);
      n_checks++; if (tmo || cyc != exp_cyc) begin n_fail++; $display("FAIL rr_spacing op%0d: got %0d (timeout=%0b) expected %0d", op, cyc, tmo, exp_cyc); end
      n_checks++; if (done !== N'(1) << g || result !== exp_q(op_a[g], op_b[g]) || result_id !== IDW'(g)) begin n_fail++; $display("FAIL rr_result op%0d: got done %b %0d id %0d expected %b %0d id %0d", op, done, result, result_id, N'(1) << g, exp_q(op_a[g], op_b[g]), g); end
      n_checks++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL rr_start_low op%0d: got %b expected 0", op, div_start); end
      m_ptr = g;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_operand_change();
    int cyc; bit tmo, ss; int g; int extra;
    logic [W-1:0] exp;
    set_op(0, 100, 7); req = 3'b001;
    g = exp_pick(req, m_ptr);
    exp = exp_q(100, 7);
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || div_dividend !== 32'd100) begin n_fail++; $display("FAIL opchg_grant: got busy %b dividend %0d expected 1 100", busy, div_dividend); end
    dividend_in[0 +: W] = 32'd9; req = '0;
    wait_done(CYC_DIV + 5, cyc, tmo, ss);
    n_checks++; if (tmo || cyc + 1 != CYC_DIV) begin n_fail++; $display("FAIL opchg_latency: got %0d (timeout=%0b) expected %0d", cyc + 1, tmo, CYC_DIV); end
    n_checks++; if (done !== N'(1) << g || result !== exp) begin n_fail++; $display("FAIL opchg_result: got done %b %0d expected %b %0d", done, result, N'(1) << g, exp); end
    m_ptr = g; extra = 0;
    repeat (6) begin @(negedge clk); if (done != '0) extra++; end
    n_checks++; if (extra != 0) begin n_fail++; $display("FAIL opchg_single_pulse: got %0d extra pulses expected 0", extra); end
  endtask

  task automatic test_reset_mid_op();
    int cyc; bit tmo, ss; int g;
    set_op(2, 12345, 5); req = 3'b100;
    @(negedge clk);          // grant edge passed, counter loaded
    repeat (26) @(negedge clk); // counter now at 10
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if ({done, busy, div_start, dbz} !== '0) begin n_fail++; $display("FAIL midrst_ctrl: got %b expected 0", {done, busy, div_start, dbz}); end
    n_checks++; if ({result, result_id, div_dividend, div_divisor} !== '0) begin n_fail++; $display("FAIL midrst_data: got %0h %0d %0h %0h expected all 0", result, result_id, div_dividend, div_divisor); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1; m_ptr = N - 1;
    g = exp_pick(req, m_ptr);
    wait_done(CYC_DIV + 5, cyc, tmo, ss);
    n_checks++; if (tmo || cyc != CYC_DIV) begin n_fail++; $display("FAIL midrst_latency: got %0d (timeout=%0b) expected %0d", cyc, tmo, CYC_DIV); end
    n_checks++; if (done !== N'(1) << g || result !== exp_q(12345, 5) || result_id !== IDW'(g)) begin n_fail++; $display("FAIL midrst_result: got done %b %0d id %0d expected %b %0d id %0d", done, result, result_id, N'(1) << g, exp_q(12345, 5), g); end
    m_ptr = g; req = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int cyc; bit tmo, ss; int g;
    set_op(1, 32'hFFFF_FFFF, 1); req = 3'b010;
    for (int op = 0; op < 2; op++) begin
      g = exp_pick(req, m_ptr);
      wait_done(CYC_DIV + 5, cyc, tmo, ss);
      n_checks++; if (tmo || cyc != CYC_DIV) begin n_fail++; $display("FAIL b2b_latency op%0d: got %0d (timeout=%0b) expected %0d", op, cyc, tmo, CYC_DIV); end
      n_checks++; if (done !== N'(1) << g || result !== 32'hFFFF_FFFF || dbz !== 1'b0 || result_id !== IDW'(g)) begin n_fail++; $display("FAIL b2b_result op%0d: got done %b %0h dbz %b id %0d expected %b ffffffff 0 %0d", op, done, result, dbz, result_id, N'(1) << g, g); end
      m_ptr = g; req = '0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle op%0d: got busy %b expected 0", op, busy); end
      if (op == 0) req = 3'b010;
    end
  endtask

  task automatic test_random();
    int cyc; bit tmo, ss; int g; int exp_cyc;
    logic [N-1:0] pend, nw;
    logic [W-1:0] a, b;
    pend = '0;
    for (int op = 0; op < 16; op++) begin
      if (pend == '0 || $urandom_range(0, 3) == 0) begin
        nw = N'($urandom_range(1, (1 << N) - 1)) & ~pend;
        for (int i = 0; i < N; i++) begin
          if (nw[i]) begin
            a = $urandom;
            case ($urandom_range(0, 3))
              0:       b = '0;
              1:       b = W'($urandom_range(1, 15));
              default: b = $urandom;
            endcase
            set_op(i, a, b);
          end
        end
        pend = pend | nw;
      end
      req = pend;
      g = exp_pick(pend, m_ptr);
      exp_cyc = (op_b[g] == '0) ? CYC_DBZ : CYC_DIV;
      wait_done(CYC_DIV + 5, cyc, tmo, ss);
      n_checks++; if (tmo || cyc != exp_cyc) begin n_fail++; $display("FAIL rand_latency op%0d: got %0d (timeout=%0b) expected %0d", op, cyc, tmo, exp_cyc); end
      n_checks++; if (done !== N'(1) << g || result_id !== IDW'(g)) begin n_fail++; $display("FAIL rand_grant op%0d: got done %b id %0d expected %b id %0d", op, done, result_id, N'(1) << g, g); end
      n_checks++; if (result !== exp_q(op_a[g], op_b[g]) || dbz !== (op_b[g] == '0)) begin n_fail++; $display("FAIL rand_result op%0d: got %0h dbz %b expected %0h dbz %b", op, result, dbz, exp_q(op_a[g], op_b[g]), op_b[g] == '0); end
      pend[g] = 1'b0; req = pend; m_ptr = g;
      @(negedge clk);
    end
    req = '0;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish within 2ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_dbz();
    test_round_robin();
    test_operand_change();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_share_ctrl
`default_nettype wire

// File: doc/div_share_ctrl.md
Name: div_share_ctrl

Overview:
Round-robin sequencer that shares one 32-bit sequential restoring divider (div32x32) between N_REQ requesters, e.g. per-axis step-period calculators in the stepper driver. It latches the granted requester's operands, drives the divider's level-sensitive start, and waits a fixed latency, because the divider's ready output carries no completion information. It then captures the quotient and returns it to the requester with a one-cycle done pulse. Divide-by-zero is short-circuited without using the divider.

Parameters:
N_REQ, 3, number of requesters (2..8)
DATA_W, 32, operand/quotient width; matches the divider
DIV_LATENCY, 36, cycles from start assertion until the quotient is valid; must be ≥34 for div32x32 (edge-detect + 32 iterations + quotient register)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester level request; held until its done pulse
dividend_in  in  N_REQ*DATA_W  packed dividends; slice i = requester i
divisor_in  in  N_REQ*DATA_W  packed divisors
done  out  N_REQ  one-cycle pulse on the bit of the served requester
result  out  DATA_W  quotient of the last completed op; held until the next completion
result_id  out  clog2(N_REQ)  requester index of result
dbz  out  1  high with done when divisor was 0; held with result
busy  out  1  high from grant until return to IDLE
div_start  out  1  to divider start (level; the divider acts on its rising edge)
div_dividend  out  DATA_W  to divider dividend, registered
div_divisor  out  DATA_W  to divider divisor, registered
div_quotient  in  DATA_W  from divider quotient

Behaviour:
- Reset (async, rst_n=0): state=IDLE; done=0, result=0, result_id=0, dbz=0, busy=0, div_start=0, div_dividend=0, div_divisor=0, cnt=0, rr pointer=N_REQ-1 (requester 0 wins first). Reset mid-operation aborts; a requester still holding req is re-served after reset.
- States: IDLE, RUN, ZERO, GAP.
- IDLE: if |req, grant = first set bit searching upward from ptr+1 mod N_REQ. On that edge: latch the granted operands into div_dividend/div_divisor, set grant id, ptr := grant, busy=1.
  - divisor≠0: go to RUN; div_start=1; cnt=DIV_LATENCY.
  - divisor=0: go to ZERO; div_start stays 0.
- RUN: cnt decrements each cycle. At the edge where cnt==0: result := div_quotient, result_id := grant, dbz := 0, done[grant] pulse, div_start := 0, go to GAP. A grant edge at E0 gives done high after edge E(DIV_LATENCY+1).
- ZERO: on the next edge: result := all-ones, dbz := 1, result_id := grant, done[grant] pulse, go to GAP.
- GAP: one cycle with div_start=0, which guarantees the divider sees a fresh rising edge. Then go to IDLE and clear busy. Minimum spacing between grants is DIV_LATENCY+3 cycles (divider path) or 3 cycles (dbz path).
- Operands are sampled only at grant. Later changes to dividend_in/divisor_in, or req dropping mid-op, do not affect the op. The result is still delivered and done still pulses.
- req of the just-served requester is ignored in the done cycle, because state is GAP.
- Fairness: with all requesters continuously requesting, grant order is 0,1,…,N_REQ-1,0,…. No requester waits more than N_REQ-1 other ops.
- done is registered and never has more than one bit set.

Decomposition:
- Shared package div_share_pkg holds the state enum (IDLE/RUN/ZERO/GAP), ID width function/constant clog2(N_REQ), and DBZ_RESULT = all-ones.
- One sub-module: rr_arbiter (combinational pick from req and ptr, outputs grant index and valid). The pointer register stays in div_share_ctrl.

Test Plan:
- Single op: req[0]=1, dividend 1000, divisor 7, with a behavioural divider model of latency 34 → done[0] pulse 37 cycles after grant edge, result=142, result_id=0, dbz=0.
- Divide-by-zero: req[1]=1, dividend 5, divisor 0 → div_start never rises; done[1] one cycle after the grant edge; result=0xFFFFFFFF, dbz=1.
- Round-robin: req=3'b111 held; operands i*100/(i+1) → done order 0,1,2,0; results 0,50,66,0; div_start low for ≥1 cycle between ops.
- Operand change mid-op: after grant, change dividend_in[0] from 100 to 9 and drop req[0] → result 100/divisor; done[0] still pulses once.
- Reset mid-op: assert rst_n=0 at cnt=10 → all outputs 0 immediately (async). After release with req[2] held → requester 0 pointer rule still applies, req[2] is granted, and the op completes correctly.
- Back-to-back: req[1] only, re-asserted on the cycle after done → next grant occurs ≥3 cycles after done; a second quotient of 0xFFFFFFFF/1 = 0xFFFFFFFF with dbz=0.
